// File: rtl/tt_um_serial_deser.sv
// Serial-frame receiver tile: start + DATA_W data bits (+ parity) + stop, valid/ack holding register.
// Optional parity state enabled by defining TT_DESER_PARITY_EN.
module tt_um_serial_deser #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PAR,
        ST_STOP
    } state_t;

    localparam logic [3:0] LAST_BIT = 4'(DATA_W - 1);

    logic [SYNC_STAGES-1:0] s_sync_q;
    logic [SYNC_STAGES-1:0] stb_sync_q;
    logic [SYNC_STAGES-1:0] ack_sync_q;
    logic                   stb_prev_q;
    logic                   ack_prev_q;

    state_t     state_q;
    logic [3:0] count_q;
    logic       dir_q;
    logic [7:0] shift_q;
    logic [7:0] shift_d;
    logic [7:0] holding_q;
    logic       valid_q;
    logic       overrun_q;
    logic       frame_err_q;
    logic       busy_q;
    logic       parity_err;

    logic s_bit;
    logic stb_edge;
    logic ack_edge;
    logic unused_ok;

    assign unused_ok = &{1'b0, ui_in[7:4]};

    // Synchronizers and edge-detect flops keep running while ena=0, so edges seen then are lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_sync_q   <= '0;
            stb_sync_q <= '0;
            ack_sync_q <= '0;
            stb_prev_q <= 1'b0;
            ack_prev_q <= 1'b0;
        end else begin
            s_sync_q   <= {s_sync_q[SYNC_STAGES-2:0], ui_in[0]};
            stb_sync_q <= {stb_sync_q[SYNC_STAGES-2:0], ui_in[1]};
            ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ui_in[3]};
            stb_prev_q <= stb_sync_q[SYNC_STAGES-1];
            ack_prev_q <= ack_sync_q[SYNC_STAGES-1];
        end
    end

    assign s_bit    = s_sync_q[SYNC_STAGES-1];
    assign stb_edge = stb_sync_q[SYNC_STAGES-1] & ~stb_prev_q;
    assign ack_edge = ack_sync_q[SYNC_STAGES-1] & ~ack_prev_q;

    // Bits above DATA_W-1 stay zero because the register is cleared at each start bit.
    always_comb begin
        shift_d = shift_q;
        if (dir_q) begin
            shift_d = {shift_q[6:0], s_bit};
        end else begin
            shift_d = shift_q >> 1;
            shift_d[DATA_W-1] = s_bit;
        end
    end

`ifdef TT_DESER_PARITY_EN
    logic parity_err_q;
    logic par_bad_q;
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            dir_q       <= 1'b0;
            shift_q     <= '0;
            holding_q   <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef TT_DESER_PARITY_EN
            parity_err_q <= 1'b0;
            par_bad_q    <= 1'b0;
`endif
        end else if (ena) begin
            // Ack clears first; a stop bit in the same cycle may then set flags again.
            if (ack_edge) begin
                valid_q     <= 1'b0;
                overrun_q   <= 1'b0;
                frame_err_q <= 1'b0;
`ifdef TT_DESER_PARITY_EN
                parity_err_q <= 1'b0;
`endif
            end
            if (stb_edge) begin
                case (state_q)
                    ST_IDLE: begin
                        if (!s_bit) begin
                            state_q <= ST_DATA;
                            count_q <= '0;
                            dir_q   <= ui_in[2];
                            shift_q <= '0;
                            busy_q  <= 1'b1;
`ifdef TT_DESER_PARITY_EN
                            par_bad_q <= 1'b0;
`endif
                        end
                    end
                    ST_DATA: begin
                        shift_q <= shift_d;
                        count_q <= count_q + 4'd1;
                        if (count_q == LAST_BIT) begin
`ifdef TT_DESER_PARITY_EN
                            state_q <= ST_PAR;
`else
                            state_q <= ST_STOP;
`endif
                        end
                    end
`ifdef TT_DESER_PARITY_EN
                    ST_PAR: begin
                        if (^{shift_q, s_bit}) begin
                            parity_err_q <= 1'b1;
                            par_bad_q    <= 1'b1;
                        end
                        state_q <= ST_STOP;
                    end
`endif
                    ST_STOP: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        if (!s_bit) begin
                            frame_err_q <= 1'b1;
`ifdef TT_DESER_PARITY_EN
                        end else if (par_bad_q) begin
                            holding_q <= holding_q;
`endif
                        end else if (valid_q && !ack_edge) begin
                            overrun_q <= 1'b1;
                        end else begin
                            holding_q <= shift_q;
                            valid_q   <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign uo_out  = holding_q;
    assign uio_out = {3'b000, parity_err, busy_q, frame_err_q, overrun_q, valid_q};
    assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_serial_deser.sv
// Directed self-checking bench for tt_um_serial_deser; define TT_DESER_PARITY_EN for the parity build.
module tb_tt_um_serial_deser;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       s_in = 1'b1;
    logic       strobe = 1'b0;
    logic       dir = 1'b1;
    logic       ack = 1'b0;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int total = 0;
    int bad = 0;

    assign ui_in = {4'b0000, ack, dir, strobe, s_in};

    tt_um_serial_deser #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic strobe_bit(input logic b);
        @(posedge clk); #1 s_in = b;
        repeat (2) @(posedge clk);
        #1 strobe = 1'b1;
        repeat (5) @(posedge clk);
        #1 strobe = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    // start bit, data bits in the chosen order, and a parity bit in the parity build
    task automatic send_head(input logic [7:0] d, input logic msb_first, input logic par_flip);
        @(posedge clk); #1 dir = msb_first;
        strobe_bit(1'b0);
        for (int i = 0; i < 8; i++)
            strobe_bit(msb_first ? d[7-i] : d[i]);
`ifdef TT_DESER_PARITY_EN
        strobe_bit((^d) ^ par_flip);
`else
        if (par_flip) strobe_bit(1'b1);
`endif
    endtask

    task automatic stop_bit(input logic b, input logic with_ack);
        @(posedge clk); #1 s_in = b;
        repeat (2) @(posedge clk);
        #1 strobe = 1'b1; ack = with_ack;
        repeat (5) @(posedge clk);
        #1 strobe = 1'b0; ack = 1'b0;
        repeat (3) @(posedge clk);
        #1 s_in = 1'b1;
    endtask

    task automatic pulse_ack();
        @(posedge clk); #1 ack = 1'b1;
        repeat (5) @(posedge clk);
        #1 ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (uo_out !== 8'h00) begin bad++; $display("FAIL reset_uo: got %h want 00", uo_out); end
        total++;
        if (uio_out !== 8'h00) begin bad++; $display("FAIL reset_uio: got %h want 00", uio_out); end
        total++;
        if (uio_oe !== 8'hFF) begin bad++; $display("FAIL uio_oe: got %h want ff", uio_oe); end
    endtask

    task automatic test_reset_midframe();
        send_head(8'h33, 1'b1, 1'b0);
        stop_bit(1'b1, 1'b0);
        #1;
        total++;
        if (uio_out !== 8'h01 || uo_out !== 8'h33) begin
            bad++; $display("FAIL pre_reset_byte: got uo=%h uio=%h want uo=33 uio=01", uo_out, uio_out);
        end
        @(posedge clk); #1 dir = 1'b1;
        strobe_bit(1'b0);
        for (int i = 0; i < 4; i++) strobe_bit(i[0]);
        #1;
        total++;
        if (uio_out[3] !== 1'b1) begin bad++; $display("FAIL midframe_busy: got %b want 1", uio_out[3]); end
        #2 rst_n = 1'b0;
        #3;
        total++;
        if (uo_out !== 8'h00 || uio_out !== 8'h00) begin
            bad++; $display("FAIL midframe_reset: got uo=%h uio=%h want 00 00", uo_out, uio_out);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        send_head(8'h5A, 1'b1, 1'b0);
        stop_bit(1'b1, 1'b0);
        #1;
        total++;
        if (uo_out !== 8'h5A || uio_out !== 8'h01) begin
            bad++; $display("FAIL after_reset_5a: got uo=%h uio=%h want 5a 01", uo_out, uio_out);
        end
        pulse_ack();
    endtask

    task automatic test_msb_latency();
        send_head(8'hA5, 1'b1, 1'b0);
        @(posedge clk); #1 s_in = 1'b1;
        repeat (2) @(posedge clk);
        #1 strobe = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (uio_out[0] !== 1'b0 || uio_out[3] !== 1'b1) begin
            bad++; $display("FAIL latency_early: got valid=%b busy=%b want 0 1", uio_out[0], uio_out[3]);
        end
        @(posedge clk); #1;
        total++;
        if (uio_out !== 8'h01 || uo_out !== 8'hA5) begin
            bad++; $display("FAIL msb_a5: got uo=%h uio=%h want a5 01", uo_out, uio_out);
        end
        repeat (2) @(posedge clk);
        #1 strobe = 1'b0;
        repeat (3) @(posedge clk);
        pulse_ack();
    endtask

    task automatic test_lsb_ack();
        send_head(8'h3C, 1'b0, 1'b0);
        stop_bit(1'b1, 1'b0);
        #1;
        total++;
        if (uo_out !== 8'h3C || uio_out !== 8'h01) begin
            bad++; $display("FAIL lsb_3c: got uo=%h uio=%h want 3c 01", uo_out, uio_out);
        end
        pulse_ack();
        total++;
        if (uo_out !== 8'h3C || uio_out !== 8'h00) begin
            bad++; $display("FAIL ack_clear: got uo=%h uio=%h want 3c 00", uo_out, uio_out);
        end
    endtask

    task automatic test_overrun();
        send_head(8'h11, 1'b1, 1'b0);
        stop_bit(1'b1, 1'b0);
        send_head(8'h22, 1'b0, 1'b0);
        stop_bit(1'b1, 1'b0);
        #1;
        total++;
        if (uo_out !== 8'h11 || uio_out !== 8'h03) begin
            bad++; $display("FAIL overrun: got uo=%h uio=%h want 11 03", uo_out, uio_out);
        end
        pulse_ack();
        total++;
        if (uio_out[2:0] !== 3'b000) begin bad++; $display("FAIL overrun_ack: got %b want 000", uio_out[2:0]); end
    endtask

    task automatic test_frame_err();
        send_head(8'hFF, 1'b1, 1'b0);
        stop_bit(1'b0, 1'b0);
        #1;
        total++;
        if (uo_out !== 8'h11 || uio_out !== 8'h04) begin
            bad++; $display("FAIL frame_err: got uo=%h uio=%h want 11 04", uo_out, uio_out);
        end
        pulse_ack();
        total++;
        if (uio_out !== 8'h00) begin bad++; $display("FAIL frame_err_ack: got %h want 00", uio_out); end
    endtask

    task automatic test_ena_gate();
        @(posedge clk); #1 ena = 1'b0;
        send_head(8'h77, 1'b1, 1'b0);
        stop_bit(1'b1, 1'b0);
        #1;
        total++;
        if (uo_out !== 8'h11 || uio_out !== 8'h00) begin
            bad++; $display("FAIL ena_gate: got uo=%h uio=%h want 11 00", uo_out, uio_out);
        end
        @(posedge clk); #1 ena = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_back_to_back();
        send_head(8'h0F, 1'b1, 1'b0);
        stop_bit(1'b1, 1'b0);
        #1;
        total++;
        if (uo_out !== 8'h0F || uio_out !== 8'h01) begin
            bad++; $display("FAIL b2b_first: got uo=%h uio=%h want 0f 01", uo_out, uio_out);
        end
        send_head(8'h81, 1'b0, 1'b0);
        stop_bit(1'b1, 1'b1);
        #1;
        total++;
        if (uo_out !== 8'h81 || uio_out !== 8'h01) begin
            bad++; $display("FAIL ack_with_stop: got uo=%h uio=%h want 81 01", uo_out, uio_out);
        end
        pulse_ack();
    endtask

`ifdef TT_DESER_PARITY_EN
    task automatic test_parity();
        send_head(8'hA5, 1'b1, 1'b0);
        stop_bit(1'b1, 1'b0);
        #1;
        total++;
        if (uo_out !== 8'hA5 || uio_out !== 8'h01) begin
            bad++; $display("FAIL parity_good: got uo=%h uio=%h want a5 01", uo_out, uio_out);
        end
        pulse_ack();
        send_head(8'hC3, 1'b1, 1'b1);
        stop_bit(1'b1, 1'b0);
        #1;
        total++;
        if (uo_out !== 8'hA5 || uio_out !== 8'h10) begin
            bad++; $display("FAIL parity_bad: got uo=%h uio=%h want a5 10", uo_out, uio_out);
        end
        pulse_ack();
        total++;
        if (uio_out !== 8'h00) begin bad++; $display("FAIL parity_ack: got %h want 00", uio_out); end
    endtask
`endif

    initial begin
        test_reset();
        test_reset_midframe();
        test_msb_latency();
        test_lsb_ack();
        test_overrun();
        test_frame_err();
        test_ena_gate();
        test_back_to_back();
`ifdef TT_DESER_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
